// File: rtl/set_seq_pkg.sv
// Shared definitions for set_sequencer: FSM state encoding and default sizing.
package set_seq_pkg;

  typedef enum logic {
    COUNT = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int DEF_ITEMS_PER_SET  = 6;
  localparam int DEF_SETS_PER_FRAME = 2;
  localparam int DEF_ITEM_W         = $clog2(DEF_ITEMS_PER_SET);
  localparam int DEF_SET_W          = (DEF_SETS_PER_FRAME > 1) ? $clog2(DEF_SETS_PER_FRAME) : 1;

endpackage

// File: rtl/mod_N_counter_en.sv
// Wrapping modulo-N counter with enable. tc_o flags the terminal value N-1.
// Any value at or above N-1 (including unreachable encodings) loads 0 on the
// next enabled edge.
module mod_N_counter_en #(
  parameter int N = 6,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  localparam logic [W-1:0] LAST = W'(N - 1);

  // Next count: increment below the terminal value, otherwise wrap to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (cnt_q >= LAST) cnt_d = '0;
      else               cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/set_sequencer.sv
// set_sequencer: accepts items over valid/ready, groups them into sets and
// sets into frames, then holds with output_valid high until out_ack.
// Optional build macro SET_SEQ_OVERRUN_EN adds a sticky overrun flag that
// records in_valid seen while holding.
module set_sequencer
  import set_seq_pkg::*;
#(
  parameter int ITEMS_PER_SET  = DEF_ITEMS_PER_SET,
  parameter int ITEM_W         = DEF_ITEM_W,
  parameter int SETS_PER_FRAME = DEF_SETS_PER_FRAME,
  parameter int SET_W          = DEF_SET_W
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              out_ack,
  output logic [ITEM_W-1:0] item_cnt,
  output logic [SET_W-1:0]  set_cnt,
  output logic              next_set,
`ifdef SET_SEQ_OVERRUN_EN
  output logic              overrun,
`endif
  output logic              output_valid
);

  state_e state_q, state_d;
  logic   next_set_q, next_set_d;
  logic   accept;
  logic   item_tc;
  logic   set_tc;
  logic   set_en;

  assign in_ready = (state_q == COUNT) && !GlobalReset;
  assign accept   = in_valid && in_ready;
  assign set_en   = accept && item_tc;

  mod_N_counter_en #(
    .N (ITEMS_PER_SET),
    .W (ITEM_W)
  ) u_item_cnt (
    .clk   (clk),
    .rst   (GlobalReset),
    .en_i  (accept),
    .cnt_o (item_cnt),
    .tc_o  (item_tc)
  );

  mod_N_counter_en #(
    .N (SETS_PER_FRAME),
    .W (SET_W)
  ) u_set_cnt (
    .clk   (clk),
    .rst   (GlobalReset),
    .en_i  (set_en),
    .cnt_o (set_cnt),
    .tc_o  (set_tc)
  );

  // Next state and set-completion pulse; the last item of the last set
  // enters HOLD on the same edge that raises next_set.
  always_comb begin
    state_d    = state_q;
    next_set_d = 1'b0;
    unique case (state_q)
      COUNT: begin
        if (set_en) begin
          next_set_d = 1'b1;
          if (set_tc) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ack) state_d = COUNT;
      end
      default: state_d = COUNT;
    endcase
  end

  // State and pulse registers; reset overrides ack and accept.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q    <= COUNT;
      next_set_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_set_q <= next_set_d;
    end
  end

  assign next_set     = next_set_q;
  assign output_valid = (state_q == HOLD);

`ifdef SET_SEQ_OVERRUN_EN
  logic overrun_q;

  // Sticky flag: any item offered while holding is recorded until reset.
  always_ff @(posedge clk) begin
    if (GlobalReset)                          overrun_q <= 1'b0;
    else if ((state_q == HOLD) && in_valid)   overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_set_sequencer.sv
// Directed testbench for set_sequencer with default parameters (6 items x 2 sets).
`timescale 1ns/1ps
module tb_set_sequencer;

  logic       clk;
  logic       GlobalReset;
  logic       in_valid;
  logic       in_ready;
  logic       out_ack;
  logic [2:0] item_cnt;
  logic [0:0] set_cnt;
  logic       next_set;
  logic       output_valid;
`ifdef SET_SEQ_OVERRUN_EN
  logic       overrun;
`endif

  int n_cmp = 0;
  int n_err = 0;

  set_sequencer dut (
    .clk          (clk),
    .GlobalReset  (GlobalReset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_ack      (out_ack),
    .item_cnt     (item_cnt),
    .set_cnt      (set_cnt),
    .next_set     (next_set),
`ifdef SET_SEQ_OVERRUN_EN
    .overrun      (overrun),
`endif
    .output_valid (output_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int it, input int st,
                           input int ns, input int ov, input int rdy);
    check_val({tag, ".item_cnt"},     32'(item_cnt),     32'(it));
    check_val({tag, ".set_cnt"},      32'(set_cnt),      32'(st));
    check_val({tag, ".next_set"},     32'(next_set),     32'(ns));
    check_val({tag, ".output_valid"}, 32'(output_valid), 32'(ov));
    check_val({tag, ".in_ready"},     32'(in_ready),     32'(rdy));
  endtask

  initial begin
    GlobalReset = 1'b1;
    in_valid    = 1'b0;
    out_ack     = 1'b0;
    tick();
    tick();
    check_all("reset", 0, 0, 0, 0, 0);
`ifdef SET_SEQ_OVERRUN_EN
    check_val("reset.overrun", 32'(overrun), 32'd0);
`endif
    GlobalReset = 1'b0;
    #1;
    check_val("reset_release.in_ready", 32'(in_ready), 32'd1);

    // Full frame at full rate.
    in_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check_all($sformatf("frame_acc%0d", i), i % 6, (i >= 6 && i < 12) ? 1 : 0,
                (i == 6 || i == 12) ? 1 : 0, (i == 12) ? 1 : 0, (i == 12) ? 0 : 1);
    end

    // Hold with in_valid asserted and no ack.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all($sformatf("hold%0d", i), 0, 0, 0, 1, 0);
`ifdef SET_SEQ_OVERRUN_EN
      check_val($sformatf("hold%0d.overrun", i), 32'(overrun), 32'd1);
`endif
    end

    // Acknowledge, then one accept.
    in_valid = 1'b0;
    out_ack  = 1'b1;
    tick();
    out_ack  = 1'b0;
    check_all("ack", 0, 0, 0, 0, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_all("post_ack_acc", 1, 0, 0, 0, 1);

    // Clean restart, then in_valid toggling each cycle.
    GlobalReset = 1'b1;
    tick();
    GlobalReset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      in_valid = 1'b1;
      tick();
      check_all($sformatf("toggle_acc%0d", k), k % 6, (k == 6) ? 1 : 0, (k == 6) ? 1 : 0, 0, 1);
      in_valid = 1'b0;
      tick();
      check_all($sformatf("toggle_idle%0d", k), k % 6, (k == 6) ? 1 : 0, 0, 0, 1);
    end

    // Reset mid-set with in_valid still asserted.
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check_all("mid_set", 4, 1, 0, 0, 1);
    GlobalReset = 1'b1;
    tick();
    check_all("mid_set_reset", 0, 0, 0, 0, 0);
    GlobalReset = 1'b0;
    in_valid    = 1'b0;
    #1;
    check_val("mid_set_release.in_ready", 32'(in_ready), 32'd1);

    // out_ack ignored while counting.
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check_all("pre_ack_count", 3, 0, 0, 0, 1);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check_all("ack_in_count", 4, 0, 0, 0, 1);

    // Reach HOLD again: 2 more in set 0, 6 in set 1.
    for (int k = 0; k < 8; k++) tick();
    check_all("hold2", 0, 0, 1, 1, 0);

    // Reset and ack together during HOLD: reset wins.
    GlobalReset = 1'b1;
    out_ack     = 1'b1;
    tick();
    check_all("hold_reset", 0, 0, 0, 0, 0);
    GlobalReset = 1'b0;
    out_ack     = 1'b0;
    in_valid    = 1'b0;
    #1;
    check_val("hold_reset_release.in_ready", 32'(in_ready), 32'd1);
`ifdef SET_SEQ_OVERRUN_EN
    check_val("hold_reset.overrun", 32'(overrun), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
